param_rob: RTL and testbench
============================

PARAM_ROB -- requirements
Module: param_rob

Interface
REQ-001 Parameters SHALL be: DEPTH, default 16, entry count, power of two, at least 4.
REQ-002 Parameters SHALL be: DISP_W, default 2, dispatch lanes; CMP_W, default 3, completion ports; RET_W, default 2, retire lanes.
REQ-003 Parameters SHALL be: DATA_W, default 32, result width; PREG_W, default 6, physical register index width; IDX_W = log2(DEPTH), derived.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 Control ports SHALL be:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all entries
REQ-006 Dispatch ports SHALL be:
- disp_valid  in  DISP_W  per-lane allocate request
- disp_pc  in  DISP_W*32  PC per lane
- disp_rd  in  DISP_W*PREG_W  new destination register
- disp_rd_old  in  DISP_W*PREG_W  previous mapping
- disp_regwrite  in  DISP_W  lane writes a register
- disp_ready  out  1  at least DISP_W entries free
- disp_idx  out  DISP_W*IDX_W  index lane k would receive, (tail+k) mod DEPTH
REQ-007 Completion ports SHALL be:
- cmp_valid  in  CMP_W  completion strobe
- cmp_idx  in  CMP_W*IDX_W  target entry
- cmp_result  in  CMP_W*DATA_W  result value
REQ-008 Retire ports SHALL be:
- ret_valid  out  RET_W  registered retire strobe
- ret_pc, ret_rd, ret_rd_old, ret_result, ret_regwrite  out  per-lane widths as dispatch  retiring entry fields
REQ-009 Status ports SHALL be:
- count  out  IDX_W+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Function
REQ-010 Dispatch SHALL allocate entries only when disp_ready=1; disp_ready SHALL be computed from registered count as (DEPTH-count) >= DISP_W, with no credit for same-cycle retires.
REQ-011 Only the leading contiguous run of set disp_valid bits from lane 0 SHALL be accepted; lanes after the first clear bit SHALL be ignored.
REQ-012 An accepted lane k SHALL write entry (tail+k) mod DEPTH with valid=1, complete=0 and its fields; tail SHALL advance by the accepted count, modulo DEPTH.
REQ-013 A completion SHALL set complete=1 and store the result only if the target entry is valid; completions to invalid entries SHALL be ignored.
REQ-014 When two completion ports target the same index in one cycle, the higher-numbered port SHALL win.
REQ-015 Each cycle, the block SHALL retire the longest prefix (0..RET_W) of entries from head that are valid and complete; no entry behind an incomplete one SHALL retire.
REQ-016 Retired entries SHALL be cleared and head SHALL advance by the retired count, modulo DEPTH.
REQ-017 Retired entries' fields SHALL appear on ret_* with ret_valid set one cycle after the retire decision; unused lanes SHALL drive ret_valid=0.
REQ-018 A completion written at edge M SHALL be retire-eligible at edge M+1, with no bypass; minimum dispatch-to-ret_valid latency SHALL be 3 edges.
REQ-019 count SHALL update as count + accepted - retired each cycle; full and empty SHALL be registered and consistent with count.
REQ-020 Flush SHALL override same-cycle dispatch, completion and retire: all entries invalid, head=tail=count=0, ret_valid=0 next cycle.

Reset
REQ-021 Reset SHALL clear all entries' valid and complete bits, set head=tail=count=0, empty=1, full=0, disp_ready=1, and drive all ret_* outputs to 0.
REQ-022 Reset SHALL take priority over flush and all inputs; reset mid-operation SHALL discard all in-flight entries.

Structure
REQ-023 The shared package typedefs SHALL hold the rob entry struct and the default ROB_DEPTH, ROB_DISP_W, ROB_CMP_W and ROB_RET_W constants.
REQ-024 The prefix-select logic SHALL be a sub-module rob_retire_select, taking per-entry ready bits from head and returning the retire count.

Verification
REQ-025 Reset, then dispatch 2 (pc 0x0, 0x4), complete idx1 then idx0 -> nothing retires until idx0 completes; both then retire together in order 0x0, 0x4.
REQ-026 Dispatch 8 cycles x 2 lanes with DEPTH=16, no completes -> full=1, count=16, disp_ready=0; a 9th dispatch is not accepted.
REQ-027 Run 40 dispatch/complete/retire cycles -> pointers wrap past 15; ret_pc order matches dispatch order exactly.
REQ-028 Ports 0 and 2 both target idx 3 with results 0xAA and 0xBB -> retired result is 0xBB.
REQ-029 Flush with 5 valid entries while dispatching 2 -> next cycle count=0, empty=1, ret_valid=0, new dispatch lands at idx 0.
REQ-030 Assert reset while entries are complete and retiring -> ret_valid=0 next cycle and all status outputs at reset values.

Source files
------------

// File: rtl/param_rob_pkg.sv
// Shared definitions for the parameterised reorder buffer.
// Holds the default geometry constants and the per-entry bookkeeping
// struct. The parameter-width fields of an entry (rd, rd_old, result) are
// kept in parallel arrays inside param_rob, because their widths are
// module parameters and cannot be fixed here.
package param_rob_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_DISP_W = 2;
    localparam int ROB_CMP_W  = 3;
    localparam int ROB_RET_W  = 2;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_PREG_W = 6;
    localparam int ROB_PC_W   = 32;

    typedef struct packed {
        logic                valid;
        logic                complete;
        logic                regwrite;
        logic [ROB_PC_W-1:0] pc;
    } rob_entry_t;

endpackage

// File: rtl/param_rob_retire_select.sv
// rob_retire_select: retire prefix selector.
// Takes the ready (valid && complete) bits of the RET_W entries starting at
// head, lane 0 = head, and returns how many of them form an unbroken ready
// run from lane 0. Anything behind the first non-ready entry is held back.
// Ports:
//   ready    in   RET_W           per-lane ready bits, lane 0 is the head
//   ret_cnt  out  $clog2(RET_W+1) length of the leading ready run
module rob_retire_select
    import param_rob_pkg::*;
#(
    parameter int RET_W = ROB_RET_W,
    parameter int CNT_W = $clog2(RET_W + 1)
) (
    input  logic [RET_W-1:0] ready,
    output logic [CNT_W-1:0] ret_cnt
);

    logic run;

    always_comb begin
        ret_cnt = '0;
        run     = 1'b1;
        for (int i = 0; i < RET_W; i++) begin
            if (run && ready[i]) begin
                ret_cnt = ret_cnt + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/param_rob.sv
// param_rob: parameterised in-order-retire reorder buffer.
// Entries are allocated at tail by up to DISP_W dispatch lanes, marked
// complete by up to CMP_W completion ports, and retired in program order
// from head, up to RET_W per cycle, with registered retire outputs.
// Ports:
//   clk, reset (sync, active-high), flush           control
//   disp_valid/pc/rd/rd_old/regwrite                 dispatch lanes (packed)
//   disp_ready, disp_idx                             allocation status/index
//   cmp_valid/idx/result                             completion ports (packed)
//   ret_valid/pc/rd/rd_old/result/regwrite           registered retire lanes
//   count, full, empty                               occupancy status
module param_rob
    import param_rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int DISP_W = ROB_DISP_W,
    parameter int CMP_W  = ROB_CMP_W,
    parameter int RET_W  = ROB_RET_W,
    parameter int DATA_W = ROB_DATA_W,
    parameter int PREG_W = ROB_PREG_W,
    // Derived from DEPTH; not meant to be overridden.
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,

    input  logic [DISP_W-1:0]          disp_valid,
    input  logic [DISP_W*ROB_PC_W-1:0] disp_pc,
    input  logic [DISP_W*PREG_W-1:0]   disp_rd,
    input  logic [DISP_W*PREG_W-1:0]   disp_rd_old,
    input  logic [DISP_W-1:0]          disp_regwrite,
    output logic                       disp_ready,
    output logic [DISP_W*IDX_W-1:0]    disp_idx,

    input  logic [CMP_W-1:0]           cmp_valid,
    input  logic [CMP_W*IDX_W-1:0]     cmp_idx,
    input  logic [CMP_W*DATA_W-1:0]    cmp_result,

    output logic [RET_W-1:0]           ret_valid,
    output logic [RET_W*ROB_PC_W-1:0]  ret_pc,
    output logic [RET_W*PREG_W-1:0]    ret_rd,
    output logic [RET_W*PREG_W-1:0]    ret_rd_old,
    output logic [RET_W*DATA_W-1:0]    ret_result,
    output logic [RET_W-1:0]           ret_regwrite,

    output logic [IDX_W:0]             count,
    output logic                       full,
    output logic                       empty
);

    localparam int CNT_W  = IDX_W + 1;
    localparam int DCNT_W = $clog2(DISP_W + 1);
    localparam int RCNT_W = $clog2(RET_W + 1);

    rob_entry_t        ent    [DEPTH];
    logic [PREG_W-1:0] rd_q   [DEPTH];
    logic [PREG_W-1:0] rdo_q  [DEPTH];
    logic [DATA_W-1:0] res_q  [DEPTH];

    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;

    logic [IDX_W-1:0]  d_idx  [DISP_W];
    logic [IDX_W-1:0]  c_idx  [CMP_W];
    logic [DATA_W-1:0] c_res  [CMP_W];
    logic [IDX_W-1:0]  r_idx  [RET_W];
    logic [RET_W-1:0]  r_rdy;

    logic [DISP_W-1:0] acc_mask;
    logic [DCNT_W-1:0] acc_cnt;
    logic              acc_run;
    logic [RCNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Readiness uses only the registered count: a retire in the same cycle
    // does not free space for dispatch until the following cycle.
    assign disp_ready = (DEPTH - int'(count)) >= DISP_W;

    for (genvar k = 0; k < DISP_W; k++) begin : g_disp
        assign d_idx[k] = tail + IDX_W'(k);
        assign disp_idx[k*IDX_W +: IDX_W] = d_idx[k];
    end

    for (genvar p = 0; p < CMP_W; p++) begin : g_cmp
        assign c_idx[p] = cmp_idx[p*IDX_W +: IDX_W];
        assign c_res[p] = cmp_result[p*DATA_W +: DATA_W];
    end

    // Retire candidates read registered complete bits only, so a completion
    // becomes retire-eligible one edge after it is written.
    for (genvar r = 0; r < RET_W; r++) begin : g_ret
        assign r_idx[r] = head + IDX_W'(r);
        assign r_rdy[r] = ent[r_idx[r]].valid & ent[r_idx[r]].complete;
    end

    rob_retire_select #(
        .RET_W (RET_W),
        .CNT_W (RCNT_W)
    ) u_retire_select (
        .ready   (r_rdy),
        .ret_cnt (ret_cnt)
    );

    // Accept only the unbroken run of requests starting at lane 0.
    always_comb begin
        acc_mask = '0;
        acc_cnt  = '0;
        acc_run  = disp_ready;
        for (int k = 0; k < DISP_W; k++) begin
            if (acc_run && disp_valid[k]) begin
                acc_mask[k] = 1'b1;
                acc_cnt     = acc_cnt + DCNT_W'(1);
            end else begin
                acc_run = 1'b0;
            end
        end
    end

    assign cnt_nxt = count + CNT_W'(acc_cnt) - CNT_W'(ret_cnt);

    // Entry control state and pointers. Within the cycle, completion writes
    // follow dispatch and retire clears follow completion, so the later
    // non-blocking assignment wins where they touch the same entry.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid    <= 1'b0;
                ent[i].complete <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            for (int k = 0; k < DISP_W; k++) begin
                if (acc_mask[k]) begin
                    ent[d_idx[k]].valid    <= 1'b1;
                    ent[d_idx[k]].complete <= 1'b0;
                    ent[d_idx[k]].regwrite <= disp_regwrite[k];
                    ent[d_idx[k]].pc       <= disp_pc[k*ROB_PC_W +: ROB_PC_W];
                end
            end
            for (int p = 0; p < CMP_W; p++) begin
                if (cmp_valid[p] && ent[c_idx[p]].valid) begin
                    ent[c_idx[p]].complete <= 1'b1;
                end
            end
            for (int r = 0; r < RET_W; r++) begin
                if (RCNT_W'(r) < ret_cnt) begin
                    ent[r_idx[r]].valid    <= 1'b0;
                    ent[r_idx[r]].complete <= 1'b0;
                end
            end
            head  <= head + IDX_W'(ret_cnt);
            tail  <= tail + IDX_W'(acc_cnt);
            count <= cnt_nxt;
            full  <= (cnt_nxt == CNT_W'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

    // Entry payload. Ascending port order makes the highest-numbered port
    // win when several completions hit the same index.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DISP_W; k++) begin
            if (acc_mask[k]) begin
                rd_q[d_idx[k]]  <= disp_rd[k*PREG_W +: PREG_W];
                rdo_q[d_idx[k]] <= disp_rd_old[k*PREG_W +: PREG_W];
            end
        end
        for (int p = 0; p < CMP_W; p++) begin
            if (cmp_valid[p] && ent[c_idx[p]].valid) begin
                res_q[c_idx[p]] <= c_res[p];
            end
        end
    end

    // Registered retire outputs, one cycle after the retire decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_valid    <= '0;
            ret_pc       <= '0;
            ret_rd       <= '0;
            ret_rd_old   <= '0;
            ret_result   <= '0;
            ret_regwrite <= '0;
        end else if (flush) begin
            ret_valid <= '0;
        end else begin
            for (int r = 0; r < RET_W; r++) begin
                ret_valid[r]                      <= (RCNT_W'(r) < ret_cnt);
                ret_pc[r*ROB_PC_W +: ROB_PC_W]    <= ent[r_idx[r]].pc;
                ret_regwrite[r]                   <= ent[r_idx[r]].regwrite;
                ret_rd[r*PREG_W +: PREG_W]        <= rd_q[r_idx[r]];
                ret_rd_old[r*PREG_W +: PREG_W]    <= rdo_q[r_idx[r]];
                ret_result[r*DATA_W +: DATA_W]    <= res_q[r_idx[r]];
            end
        end
    end

endmodule

// File: tb/tb_param_rob.sv
// Testbench for param_rob: directed scenarios followed by randomized
// dispatch/complete/flush traffic, checked by a program-order scoreboard.
module tb_param_rob;
    import param_rob_pkg::*;

    localparam int DEPTH  = ROB_DEPTH;
    localparam int DISP_W = ROB_DISP_W;
    localparam int CMP_W  = ROB_CMP_W;
    localparam int RET_W  = ROB_RET_W;
    localparam int DATA_W = ROB_DATA_W;
    localparam int PREG_W = ROB_PREG_W;
    localparam int IDX_W  = $clog2(DEPTH);

    logic                    clk = 1'b0;
    logic                    reset, flush;
    logic [DISP_W-1:0]       disp_valid, disp_regwrite;
    logic [DISP_W*32-1:0]    disp_pc;
    logic [DISP_W*PREG_W-1:0] disp_rd, disp_rd_old;
    logic                    disp_ready;
    logic [DISP_W*IDX_W-1:0] disp_idx;
    logic [CMP_W-1:0]        cmp_valid;
    logic [CMP_W*IDX_W-1:0]  cmp_idx;
    logic [CMP_W*DATA_W-1:0] cmp_result;
    logic [RET_W-1:0]        ret_valid, ret_regwrite;
    logic [RET_W*32-1:0]     ret_pc;
    logic [RET_W*PREG_W-1:0] ret_rd, ret_rd_old;
    logic [RET_W*DATA_W-1:0] ret_result;
    logic [IDX_W:0]          count;
    logic                    full, empty;

    param_rob dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_rd(disp_rd),
        .disp_rd_old(disp_rd_old), .disp_regwrite(disp_regwrite),
        .disp_ready(disp_ready), .disp_idx(disp_idx),
        .cmp_valid(cmp_valid), .cmp_idx(cmp_idx), .cmp_result(cmp_result),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_rd(ret_rd),
        .ret_rd_old(ret_rd_old), .ret_result(ret_result),
        .ret_regwrite(ret_regwrite),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: the ROB contents as a program-order list.
    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [PREG_W-1:0] rd;
        logic [PREG_W-1:0] rd_old;
        logic        rw;
        bit          done;
        logic [DATA_W-1:0] res;
    } rec_t;

    typedef struct {
        int nret;
        int cnt;
        int tail;
    } st_t;

    rec_t prog[$];
    rec_t exp_q[$];
    st_t  st_q[$];
    int   m_tail = 0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] last_ret_res = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_step();
        st_t s;
        rec_t r;
        int n, acc;
        bit rdy, run;
        rdy = (DEPTH - prog.size()) >= DISP_W;
        n = 0;
        if (reset || flush) begin
            prog.delete();
            m_tail = 0;
        end else begin
            while (n < RET_W && n < prog.size() && prog[n].done) n++;
            for (int i = 0; i < n; i++) exp_q.push_back(prog.pop_front());
            for (int p = 0; p < CMP_W; p++) begin
                if (cmp_valid[p]) begin
                    foreach (prog[j]) begin
                        if (prog[j].idx == int'(cmp_idx[p*IDX_W +: IDX_W])) begin
                            prog[j].done = 1'b1;
                            prog[j].res  = cmp_result[p*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            acc = 0;
            run = rdy;
            for (int k = 0; k < DISP_W; k++) begin
                if (run && disp_valid[k]) begin
                    r.idx    = (m_tail + k) % DEPTH;
                    r.pc     = disp_pc[k*32 +: 32];
                    r.rd     = disp_rd[k*PREG_W +: PREG_W];
                    r.rd_old = disp_rd_old[k*PREG_W +: PREG_W];
                    r.rw     = disp_regwrite[k];
                    r.done   = 1'b0;
                    r.res    = '0;
                    prog.push_back(r);
                    acc++;
                end else begin
                    run = 1'b0;
                end
            end
            m_tail = (m_tail + acc) % DEPTH;
        end
        s.nret = n;
        s.cnt  = prog.size();
        s.tail = m_tail;
        st_q.push_back(s);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic clr();
        flush = 1'b0; disp_valid = '0; cmp_valid = '0;
    endtask

    task automatic set_disp(input int k, input logic [31:0] pc);
        disp_valid[k] = 1'b1;
        disp_pc[k*32 +: 32] = pc;
        disp_rd[k*PREG_W +: PREG_W] = PREG_W'($urandom);
        disp_rd_old[k*PREG_W +: PREG_W] = PREG_W'($urandom);
        disp_regwrite[k] = 1'($urandom);
    endtask

    task automatic set_cmp(input int p, input int idx, input logic [DATA_W-1:0] v);
        cmp_valid[p] = 1'b1;
        cmp_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
        cmp_result[p*DATA_W +: DATA_W] = v;
    endtask

    // Monitor: compare every post-edge state against the scoreboard.
    initial begin
        st_t s;
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() != 0) begin
                s = st_q.pop_front();
                chk("count", 64'(count), 64'(s.cnt));
                chk("full", 64'(full), 64'(s.cnt == DEPTH));
                chk("empty", 64'(empty), 64'(s.cnt == 0));
                chk("disp_ready", 64'(disp_ready), 64'((DEPTH - s.cnt) >= DISP_W));
                chk("disp_idx0", 64'(disp_idx[IDX_W-1:0]), 64'(s.tail));
                chk("ret_valid", 64'(ret_valid), 64'((1 << s.nret) - 1));
                for (int r = 0; r < s.nret; r++) begin
                    if (exp_q.size() == 0) begin
                        chk("ret_underflow", 64'(exp_q.size()), 64'(1));
                    end else begin
                        e = exp_q.pop_front();
                        chk("ret_pc", 64'(ret_pc[r*32 +: 32]), 64'(e.pc));
                        chk("ret_rd", 64'(ret_rd[r*PREG_W +: PREG_W]), 64'(e.rd));
                        chk("ret_rd_old", 64'(ret_rd_old[r*PREG_W +: PREG_W]), 64'(e.rd_old));
                        chk("ret_regwrite", 64'(ret_regwrite[r]), 64'(e.rw));
                        chk("ret_result", 64'(ret_result[r*DATA_W +: DATA_W]), 64'(e.res));
                        last_ret_res = ret_result[r*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        reset = 1'b1;
        clr();
        disp_pc = '0; disp_rd = '0; disp_rd_old = '0; disp_regwrite = '0;
        cmp_idx = '0; cmp_result = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_ready", 64'(disp_ready), 64'(1));
        chk("rst_ret_valid", 64'(ret_valid), 64'(0));
        chk("rst_ret_pc", 64'(ret_pc), 64'(0));
        reset = 1'b0;

        // Out-of-order completion, in-order retire.
        set_disp(0, 32'h0); set_disp(1, 32'h4);
        tick();
        clr(); set_cmp(0, 1, DATA_W'($urandom));
        tick();
        clr();
        tick();
        tick();
        chk("hold_behind_incomplete", 64'(ret_valid), 64'(0));
        set_cmp(0, 0, DATA_W'($urandom));
        tick();
        clr();
        tick();
        chk("pair_ret_valid", 64'(ret_valid), 64'(2'b11));
        chk("pair_ret_pc0", 64'(ret_pc[31:0]), 64'(32'h0));
        chk("pair_ret_pc1", 64'(ret_pc[63:32]), 64'(32'h4));
        tick();

        // Fill to capacity; the next dispatch is refused.
        for (int i = 0; i < 8; i++) begin
            clr(); set_disp(0, 32'h100 + 8*i); set_disp(1, 32'h104 + 8*i);
            tick();
        end
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_count", 64'(count), 64'(16));
        chk("fill_ready", 64'(disp_ready), 64'(0));
        clr(); set_disp(0, 32'h200); set_disp(1, 32'h204);
        tick();
        chk("ninth_dispatch_count", 64'(count), 64'(16));
        clr(); flush = 1'b1;
        tick();

        // Flush with 5 entries (two already complete) while dispatching.
        clr(); set_disp(0, 32'h300); set_disp(1, 32'h304);
        tick();
        clr(); set_disp(0, 32'h308); set_disp(1, 32'h30c);
        tick();
        clr(); set_disp(0, 32'h310); set_cmp(0, 0, 32'h1); set_cmp(1, 1, 32'h2);
        tick();
        clr(); flush = 1'b1; set_disp(0, 32'h400); set_disp(1, 32'h404);
        tick();
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_empty", 64'(empty), 64'(1));
        chk("flush_ret_valid", 64'(ret_valid), 64'(0));
        chk("flush_disp_idx", 64'(disp_idx[IDX_W-1:0]), 64'(0));

        // Two ports hit idx 3 in one cycle; the higher port's result wins.
        clr(); set_disp(0, 32'h500); set_disp(1, 32'h504);
        tick();
        clr(); set_disp(0, 32'h508); set_disp(1, 32'h50c); set_cmp(1, 0, 32'h11);
        tick();
        clr(); set_cmp(0, 3, 32'hAA); set_cmp(2, 3, 32'hBB); set_cmp(1, 1, 32'h22);
        tick();
        clr(); set_cmp(1, 2, 32'h33);
        tick();
        clr();
        tick(); tick(); tick();
        chk("cmp_port_priority", 64'(last_ret_res), 64'(32'hBB));

        // Reset while completed entries are retiring.
        clr(); set_disp(0, 32'h600); set_disp(1, 32'h604);
        tick();
        clr(); set_disp(0, 32'h608); set_disp(1, 32'h60c);
        set_cmp(0, 4, 32'h44); set_cmp(1, 5, 32'h55);
        tick();
        clr(); set_cmp(0, 6, 32'h66); set_cmp(1, 7, 32'h77);
        tick();
        clr(); reset = 1'b1;
        tick();
        chk("midrst_ret_valid", 64'(ret_valid), 64'(0));
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_empty", 64'(empty), 64'(1));
        chk("midrst_full", 64'(full), 64'(0));
        chk("midrst_ready", 64'(disp_ready), 64'(1));
        chk("midrst_ret_pc", 64'(ret_pc), 64'(0));
        chk("midrst_ret_result", 64'(ret_result), 64'(0));
        reset = 1'b0;

        // Randomized traffic; pointers wrap many times.
        for (int c = 0; c < 400; c++) begin
            clr();
            if ($urandom_range(0, 49) == 0) flush = 1'b1;
            for (int k = 0; k < DISP_W; k++) begin
                if ($urandom_range(0, 3) != 0) set_disp(k, $urandom & 32'hFFFF_FFFC);
            end
            for (int p = 0; p < CMP_W; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (prog.size() > 0 && $urandom_range(0, 3) != 0) begin
                        sel = $urandom_range(0, prog.size() - 1);
                        set_cmp(p, prog[sel].idx, DATA_W'($urandom));
                    end else begin
                        set_cmp(p, $urandom_range(0, DEPTH - 1), DATA_W'($urandom));
                    end
                end
            end
            tick();
        end

        // Drain: complete everything outstanding, bounded.
        for (int c = 0; c < 200; c++) begin
            int p;
            if (prog.size() == 0) break;
            clr();
            p = 0;
            foreach (prog[j]) begin
                if (!prog[j].done && p < CMP_W) begin
                    set_cmp(p, prog[j].idx, DATA_W'($urandom));
                    p++;
                end
            end
            tick();
        end
        clr();
        tick();
        tick();
        chk("drain_empty", 64'(empty), 64'(1));
        chk("drain_scoreboard", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
